// File: rtl/mux_pkg.sv
// Shared definitions for the mux4 serializer.
//   state_t  : FSM state encoding
//   N_INPUTS : data inputs of the downstream mux4 (bits per word)
//   SEL_W    : width of the mux4 select
package mux_pkg;
  localparam int N_INPUTS = 4;
  localparam int SEL_W    = 2;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;
endpackage

// File: rtl/tick_divider.sv
// Per-bit hold counter: counts 0..DIV-1 while enabled and wraps to 0
// after the terminal count.
//   clk, rst_n : clock, async active-low reset
//   i_clr      : synchronous clear (wins over i_en)
//   i_en       : advance the count this cycle
//   o_tc       : terminal count (count == DIV-1)
module tick_divider #(
  parameter int DIV = 1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_clr,
  input  logic i_en,
  output logic o_tc
);
  logic [7:0] r_count;

  // With DIV=1 this is always true and the count never leaves 0.
  assign o_tc = (r_count == 8'(DIV - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      r_count <= '0;
    else if (i_clr)  r_count <= '0;
    else if (i_en)   r_count <= o_tc ? 8'd0 : r_count + 8'd1;
  end
endmodule

// File: rtl/mux4_serializer.sv
// Serializes a 4-bit word through an external mux4 by stepping its select
// LSB first, holding each select DIV cycles, and captures the mux output
// back into o_echo for comparison with the sent word.
//   clk, rst_n    : clock, async active-low reset
//   i_valid/i_ready/i_data : upstream word handshake
//   o_word, o_sel : drive the mux4 a[3:0] / s[1:0]
//   y             : mux4 output returned to us
//   o_bit_strobe  : last cycle of each bit (y sampled at its end)
//   o_busy        : serializing
//   o_done        : one-cycle frame-complete pulse, o_echo/o_match valid
//   o_echo        : captured bits, o_match = (o_echo == o_word) during o_done
module mux4_serializer
  import mux_pkg::*;
#(
  parameter int DIV = 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                i_valid,
  output logic                i_ready,
  input  logic [N_INPUTS-1:0] i_data,
  output logic [N_INPUTS-1:0] o_word,
  output logic [SEL_W-1:0]    o_sel,
  input  logic                y,
  output logic                o_bit_strobe,
  output logic                o_busy,
  output logic                o_done,
  output logic [N_INPUTS-1:0] o_echo,
  output logic                o_match
);
  state_t                r_state;
  logic                  r_armed;   // low until the first edge after reset
  logic [N_INPUTS-1:0]   r_word;
  logic [N_INPUTS-1:0]   r_echo;
  logic [SEL_W-1:0]      r_sel;
  logic                  w_tc;
  logic                  w_accept;
  logic                  w_busy;
  logic                  w_strobe;

  // i_ready stays low through reset and rises on the first edge after it.
  assign i_ready  = (r_state == ST_IDLE) && r_armed;
  assign w_accept = i_ready && i_valid;
  assign w_busy   = (r_state == ST_SHIFT);
  assign w_strobe = w_busy && w_tc;

  tick_divider #(.DIV(DIV)) u_div (
    .clk   (clk),
    .rst_n (rst_n),
    .i_clr (w_accept),
    .i_en  (w_busy),
    .o_tc  (w_tc)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_armed <= 1'b0;
      r_word  <= '0;
      r_sel   <= '0;
      r_echo  <= '0;
    end else begin
      r_armed <= 1'b1;
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            r_word  <= i_data;
            r_sel   <= '0;
            r_echo  <= '0;
            r_state <= ST_SHIFT;
          end
        end
        ST_SHIFT: begin
          if (w_strobe) begin
            r_echo[r_sel] <= y;
            if (r_sel == SEL_W'(N_INPUTS - 1)) r_state <= ST_DONE;
            else                               r_sel   <= r_sel + 1'b1;
          end
        end
        ST_DONE:  r_state <= ST_IDLE;
        default:  r_state <= ST_IDLE;
      endcase
    end
  end

  assign o_word       = r_word;
  assign o_sel        = r_sel;
  assign o_echo       = r_echo;
  assign o_busy       = w_busy;
  assign o_bit_strobe = w_strobe;
  assign o_done       = (r_state == ST_DONE);
  assign o_match      = o_done && (r_echo == r_word);
endmodule

// File: tb/tb_mux4_serializer.sv
module tb_mux4_serializer;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  // DIV=1 instance
  logic r1n, v1, rdy1, y1, stb1, busy1, done1, match1, f1;
  logic [3:0] d1, word1, echo1;
  logic [1:0] sel1;
  // DIV=3 instance
  logic r3n, v3, rdy3, y3, stb3, busy3, done3, match3;
  logic [3:0] d3, word3, echo3;
  logic [1:0] sel3;

  // mux4 loopback, with a stuck-at-0 fault option on the DIV=1 side
  assign y1 = f1 ? 1'b0 : word1[sel1];
  assign y3 = word3[sel3];

  mux4_serializer #(.DIV(1)) u_dut1 (
    .clk(clk), .rst_n(r1n), .i_valid(v1), .i_ready(rdy1), .i_data(d1),
    .o_word(word1), .o_sel(sel1), .y(y1), .o_bit_strobe(stb1),
    .o_busy(busy1), .o_done(done1), .o_echo(echo1), .o_match(match1));

  mux4_serializer #(.DIV(3)) u_dut3 (
    .clk(clk), .rst_n(r3n), .i_valid(v3), .i_ready(rdy3), .i_data(d3),
    .o_word(word3), .o_sel(sel3), .y(y3), .o_bit_strobe(stb3),
    .o_busy(busy3), .o_done(done3), .o_echo(echo3), .o_match(match3));

  // Bounded wait for i_ready of DIV=1 instance, sampled on negedge.
  task automatic wait_rdy1();
    int k;
    k = 0;
    @(negedge clk);
    while (rdy1 !== 1'b1 && k < 50) begin @(negedge clk); k++; end
    n_cmp++;
    if (rdy1 !== 1'b1) begin n_err++; $display("FAIL wait_rdy1 timeout: got %b need 1", rdy1); end
  endtask

  task automatic wait_rdy3();
    int k;
    k = 0;
    @(negedge clk);
    while (rdy3 !== 1'b1 && k < 50) begin @(negedge clk); k++; end
    n_cmp++;
    if (rdy3 !== 1'b1) begin n_err++; $display("FAIL wait_rdy3 timeout: got %b need 1", rdy3); end
  endtask

  task automatic test_reset();
    r1n = 1'b0; r3n = 1'b0; v1 = 1'b0; v3 = 1'b0; d1 = '0; d3 = '0; f1 = 1'b0;
    #2;
    n_cmp++;
    if ({rdy1, busy1, done1, stb1, match1, word1, sel1, echo1} !== 15'd0) begin
      n_err++; $display("FAIL reset_dut1: got %b need 0", {rdy1, busy1, done1, stb1, match1, word1, sel1, echo1});
    end
    n_cmp++;
    if ({rdy3, busy3, done3, stb3, match3, word3, sel3, echo3} !== 15'd0) begin
      n_err++; $display("FAIL reset_dut3: got %b need 0", {rdy3, busy3, done3, stb3, match3, word3, sel3, echo3});
    end
    @(negedge clk); r1n = 1'b1; r3n = 1'b1;
    #1;
    n_cmp++;
    if (rdy1 !== 1'b0) begin n_err++; $display("FAIL rdy_before_edge: got %b need 0", rdy1); end
    @(negedge clk);
    n_cmp++;
    if (rdy1 !== 1'b1 || rdy3 !== 1'b1) begin
      n_err++; $display("FAIL rdy_after_edge: got %b%b need 11", rdy1, rdy3);
    end
  endtask

  // 4'b1010 at DIV=1: select 0..3 on cycles 1-4, done on 5.
  task automatic test_div1_frame();
    wait_rdy1();
    v1 = 1'b1; d1 = 4'b1010;
    @(posedge clk); #1 v1 = 1'b0;
    for (int c = 1; c <= 4; c++) begin
      @(negedge clk);
      n_cmp++;
      if (sel1 !== 2'(c - 1) || busy1 !== 1'b1 || stb1 !== 1'b1 || done1 !== 1'b0 || rdy1 !== 1'b0) begin
        n_err++;
        $display("FAIL div1_shift c%0d: sel=%0d busy=%b stb=%b done=%b rdy=%b need sel=%0d 1 1 0 0",
                 c, sel1, busy1, stb1, done1, rdy1, c - 1);
      end
    end
    @(negedge clk);
    n_cmp++;
    if (done1 !== 1'b1 || echo1 !== 4'b1010 || match1 !== 1'b1 || busy1 !== 1'b0 || stb1 !== 1'b0) begin
      n_err++;
      $display("FAIL div1_done: done=%b echo=%b match=%b busy=%b stb=%b need 1 1010 1 0 0",
               done1, echo1, match1, busy1, stb1);
    end
    @(negedge clk);
    n_cmp++;
    if (rdy1 !== 1'b1 || done1 !== 1'b0 || word1 !== 4'b1010 || sel1 !== 2'd3 || echo1 !== 4'b1010) begin
      n_err++;
      $display("FAIL div1_hold: rdy=%b done=%b word=%b sel=%0d echo=%b need 1 0 1010 3 1010",
               rdy1, done1, word1, sel1, echo1);
    end
  endtask

  // 4'b0110 at DIV=3: strobes at 3,6,9,12, done on 13.
  task automatic test_div3_frame();
    wait_rdy3();
    v3 = 1'b1; d3 = 4'b0110;
    @(posedge clk); #1 v3 = 1'b0;
    for (int c = 1; c <= 12; c++) begin
      @(negedge clk);
      n_cmp++;
      if (sel3 !== 2'((c - 1) / 3) || busy3 !== 1'b1 || stb3 !== (c % 3 == 0) || done3 !== 1'b0) begin
        n_err++;
        $display("FAIL div3_shift c%0d: sel=%0d busy=%b stb=%b done=%b need sel=%0d 1 %b 0",
                 c, sel3, busy3, stb3, done3, (c - 1) / 3, (c % 3 == 0));
      end
    end
    @(negedge clk);
    n_cmp++;
    if (done3 !== 1'b1 || echo3 !== 4'b0110 || match3 !== 1'b1 || busy3 !== 1'b0) begin
      n_err++;
      $display("FAIL div3_done: done=%b echo=%b match=%b busy=%b need 1 0110 1 0", done3, echo3, match3, busy3);
    end
    @(negedge clk);
    n_cmp++;
    if (rdy3 !== 1'b1 || done3 !== 1'b0) begin
      n_err++; $display("FAIL div3_idle: rdy=%b done=%b need 1 0", rdy3, done3);
    end
  endtask

  // i_valid held high: 4'hF then 4'h3; 4'h3 taken on cycle 6.
  task automatic test_back_to_back();
    wait_rdy1();
    v1 = 1'b1; d1 = 4'hF;
    @(posedge clk); #1 d1 = 4'h3;
    for (int c = 1; c <= 5; c++) begin
      @(negedge clk);
      n_cmp++;
      if (rdy1 !== 1'b0 || word1 !== 4'hF) begin
        n_err++; $display("FAIL b2b_blocked c%0d: rdy=%b word=%h need 0 f", c, rdy1, word1);
      end
    end
    n_cmp++;
    if (done1 !== 1'b1 || echo1 !== 4'hF || match1 !== 1'b1) begin
      n_err++; $display("FAIL b2b_done1: done=%b echo=%h match=%b need 1 f 1", done1, echo1, match1);
    end
    @(negedge clk);
    n_cmp++;
    if (rdy1 !== 1'b1) begin n_err++; $display("FAIL b2b_rdy6: got %b need 1", rdy1); end
    @(posedge clk); #1 v1 = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (busy1 !== 1'b1 || word1 !== 4'h3 || sel1 !== 2'd0 || echo1 !== 4'h0) begin
      n_err++; $display("FAIL b2b_accept2: busy=%b word=%h sel=%0d echo=%h need 1 3 0 0", busy1, word1, sel1, echo1);
    end
    repeat (4) @(negedge clk);
    n_cmp++;
    if (done1 !== 1'b1 || echo1 !== 4'h3 || match1 !== 1'b1) begin
      n_err++; $display("FAIL b2b_done2: done=%b echo=%h match=%b need 1 3 1", done1, echo1, match1);
    end
  endtask

  // mux output stuck at 0: echo 0, no match.
  task automatic test_fault();
    wait_rdy1();
    f1 = 1'b1;
    v1 = 1'b1; d1 = 4'hF;
    @(posedge clk); #1 v1 = 1'b0;
    repeat (5) @(negedge clk);
    n_cmp++;
    if (done1 !== 1'b1 || echo1 !== 4'h0 || match1 !== 1'b0) begin
      n_err++; $display("FAIL fault_echo: done=%b echo=%h match=%b need 1 0 0", done1, echo1, match1);
    end
    f1 = 1'b0;
  endtask

  // Reset on cycle 2 of a frame: immediate clear, no done, next frame clean.
  task automatic test_reset_midframe();
    int seen_done;
    wait_rdy1();
    v1 = 1'b1; d1 = 4'hA;
    @(posedge clk); #1 v1 = 1'b0;
    @(negedge clk);
    @(negedge clk);
    n_cmp++;
    if (busy1 !== 1'b1 || sel1 !== 2'd1) begin
      n_err++; $display("FAIL midrst_pre: busy=%b sel=%0d need 1 1", busy1, sel1);
    end
    r1n = 1'b0;
    #1;
    n_cmp++;
    if ({rdy1, busy1, done1, stb1, match1, word1, sel1, echo1} !== 15'd0) begin
      n_err++; $display("FAIL midrst_async: got %b need 0", {rdy1, busy1, done1, stb1, match1, word1, sel1, echo1});
    end
    seen_done = 0;
    repeat (2) begin @(negedge clk); if (done1 === 1'b1) seen_done++; end
    r1n = 1'b1;
    repeat (6) begin @(negedge clk); if (done1 === 1'b1) seen_done++; end
    n_cmp++;
    if (seen_done != 0) begin n_err++; $display("FAIL midrst_no_done: got %0d pulses need 0", seen_done); end
    wait_rdy1();
    v1 = 1'b1; d1 = 4'h5;
    @(posedge clk); #1 v1 = 1'b0;
    repeat (5) @(negedge clk);
    n_cmp++;
    if (done1 !== 1'b1 || echo1 !== 4'h5 || match1 !== 1'b1 || word1 !== 4'h5) begin
      n_err++; $display("FAIL midrst_next: done=%b echo=%h match=%b word=%h need 1 5 1 5", done1, echo1, match1, word1);
    end
  endtask

  // done and strobe never together; busy never with done.
  always @(negedge clk) begin
    if (r1n === 1'b1 && r3n === 1'b1) begin
      if ((done1 && stb1) || (done3 && stb3) || (done1 && busy1) || (done3 && busy3)) begin
        n_cmp++; n_err++;
        $display("FAIL excl: done1=%b stb1=%b busy1=%b done3=%b stb3=%b busy3=%b", done1, stb1, busy1, done3, stb3, busy3);
      end
    end
  end

  initial begin
    test_reset();
    test_div1_frame();
    test_div3_frame();
    test_back_to_back();
    test_fault();
    test_reset_midframe();
    repeat (2) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
